pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter stage of the MIPS pipeline. Holds the PC, selects the next PC, and drives the IF-stage address and the PC+4 value. Its PC+4 output feeds the branch-target adder; it consumes that adder's branch target plus the jump targets resolved in ID. A run/step/halt FSM lets the debug unit start, single-step and stop fetch.

Parameters:
BITS_SIZE, 32, width of PC and all address ports
PC_RESET, 32'h0000_0000, PC value after reset and in IDLE
PC_INC, 4, byte increment per sequential fetch

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  debug unit: leave IDLE
i_step_mode  in  1  1 = single-step mode, 0 = free run
i_step  in  1  one-cycle pulse: permit one PC update in STEP
i_stall  in  1  hazard unit: hold PC (load-use)
i_branch_taken  in  1  branch resolved taken in ID
i_pc_branch  in  BITS_SIZE  branch target from branch-target adder
i_jump  in  1  J/JAL in ID
i_pc_jump  in  BITS_SIZE  absolute jump target, assembled upstream
i_jump_reg  in  1  JR/JALR in ID
i_pc_jreg  in  BITS_SIZE  register jump target
i_halt_detected  in  1  instruction at o_pc is HALT
o_pc  out  BITS_SIZE  current fetch address (registered)
o_pc4  out  BITS_SIZE  o_pc + PC_INC (combinational), to branch-target adder and IF/ID
o_valid  out  1  IF/ID write enable this cycle
o_flush  out  1  squash the IF/ID entry (redirect taken)
o_halted  out  1  registered, 1 while in HALT
o_fetch_count  out  BITS_SIZE  number of PC loads since reset

Behaviour:
- Reset (i_reset=1 at edge):
  - state=IDLE, o_pc=PC_RESET, o_fetch_count=0, o_halted=0.
  - Combinational outputs o_valid and o_flush are 0 while in IDLE.
  - Reset mid-operation discards everything, including the HALT state.
- FSM states: IDLE, RUN, STEP, HALT.
  - IDLE: if i_start=1, go to STEP when i_step_mode=1, otherwise RUN. PC holds.
  - RUN: i_step_mode=1 -> STEP next cycle. upd_en=1.
  - STEP: i_step_mode=0 -> RUN next cycle. upd_en=i_step.
  - HALT: terminal until reset. i_start, i_step and redirects are ignored. o_halted=1.
- upd_en is 0 in IDLE and HALT.
- redirect = upd_en & (i_branch_taken | i_jump_reg | i_jump).
- Next-PC priority, evaluated only when upd_en=1:
  - i_branch_taken -> i_pc_branch
  - else i_jump_reg -> i_pc_jreg
  - else i_jump -> i_pc_jump
  - else, if !i_stall and !i_halt_detected -> o_pc4
  - else hold.
- Redirect beats stall: a redirect loads its target even when i_stall=1.
- Redirect beats halt: a HALT fetched on the wrong path is squashed and the state does not change.
- Halt: when upd_en & i_halt_detected & !redirect & !i_stall, the PC holds on the HALT address and the state becomes HALT on the next edge.
- Targets: bits [1:0] are forced to 0 before loading. The PC never holds a misaligned value.
- Arithmetic: o_pc4 = o_pc + PC_INC, modulo 2^BITS_SIZE. 32'hFFFF_FFFC wraps to 0 with no flag.
- o_valid = upd_en & !i_stall & !redirect & !(i_halt_detected & !redirect).
- o_flush = redirect. The IF/ID register loads a bubble.
- o_fetch_count increments by 1 on every edge where the PC register loads a new value (sequential or redirect). It wraps modulo 2^BITS_SIZE.
- Latency: a redirect asserted in cycle N gives o_pc=target in cycle N+1. There is exactly one squashed slot.
- In STEP, an i_step pulse with i_stall=1 and no redirect is consumed without advancing the PC. The debug unit re-pulses.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, STEP=2'd2, HALT=2'd3)
  - PC_INC
  - PC_RESET
  - the BITS_SIZE default, also used by the branch-target adder and IF/ID register.
- One natural sub-module: pc_next_mux. It is purely combinational: priority select plus low-bit alignment, taking upd_en, stall, halt and the three targets. The FSM, PC register and counter stay in pc_fetch_unit.

Test Plan:
- Reset, i_start=1, i_step_mode=0, no events for 4 cycles -> o_pc 0,4,8,12,16; o_valid=1; o_fetch_count=4.
- In RUN with o_pc=0x20, i_branch_taken=1, i_pc_branch=0x100 and i_stall=1 in the same cycle -> o_flush=1, next o_pc=0x100, count +1.
- i_branch_taken=1 (0x40) with i_jump=1 (0x80) and i_jump_reg=1 (0xC0) -> o_pc=0x40. Repeat with the branch low -> 0xC0. Repeat with i_pc_jump=0x83 and only i_jump -> 0x80.
- i_halt_detected=1 at o_pc=0x30 with no redirect -> o_pc stays 0x30, o_halted=1 next cycle. Later i_start and i_step have no effect. i_reset -> o_pc=0, IDLE.
- i_halt_detected=1 together with i_branch_taken (0x200) -> o_pc=0x200, stays RUN, o_halted=0.
- STEP mode: 3 idle cycles then one i_step pulse -> o_pc advances exactly once (0->4). An i_step pulse with i_stall=1 -> no advance. Start RUN at o_pc=0xFFFF_FFFC -> wraps to 0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC stage and its neighbours.
// Holds FSM encoding, PC width default, reset value and increment.
package pc_fetch_unit_pkg;

    localparam int                BITS_SIZE = 32;
    localparam int                PC_INC    = 4;
    localparam logic [BITS_SIZE-1:0] PC_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    // Drop the two low address bits so the PC stays word aligned.
    function automatic logic [BITS_SIZE-1:0] align_word(
        input logic [BITS_SIZE-1:0] addr
    );
        return {addr[BITS_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: branch > jump-reg > jump > sequential > hold.
// In: upd_en, stall, halt, redirect requests and targets, pc, pc4.
// Out: o_pc_next (aligned), o_load (PC register enable), o_redirect.
module pc_next_mux #(
    parameter int BITS_SIZE = 32
) (
    input  logic                 i_upd_en,
    input  logic                 i_stall,
    input  logic                 i_halt,
    input  logic                 i_branch_taken,
    input  logic [BITS_SIZE-1:0] i_pc_branch,
    input  logic                 i_jump_reg,
    input  logic [BITS_SIZE-1:0] i_pc_jreg,
    input  logic                 i_jump,
    input  logic [BITS_SIZE-1:0] i_pc_jump,
    input  logic [BITS_SIZE-1:0] i_pc,
    input  logic [BITS_SIZE-1:0] i_pc4,
    output logic [BITS_SIZE-1:0] o_pc_next,
    output logic                 o_load,
    output logic                 o_redirect
);

    logic seq_adv;

    assign o_redirect = i_upd_en
                      & (i_branch_taken | i_jump_reg | i_jump);

    // Sequential advance is blocked by a stall or a HALT at o_pc.
    assign seq_adv = i_upd_en & ~i_stall & ~i_halt;

    assign o_load = o_redirect | seq_adv;

    always_comb begin
        o_pc_next = i_pc;
        if (i_upd_en) begin
            if (i_branch_taken) begin
                o_pc_next = {i_pc_branch[BITS_SIZE-1:2], 2'b00};
            end else if (i_jump_reg) begin
                o_pc_next = {i_pc_jreg[BITS_SIZE-1:2], 2'b00};
            end else if (i_jump) begin
                o_pc_next = {i_pc_jump[BITS_SIZE-1:2], 2'b00};
            end else if (seq_adv) begin
                o_pc_next = {i_pc4[BITS_SIZE-1:2], 2'b00};
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register, run/step/halt FSM, fetch counter.
// Ports: debug controls (start/step_mode/step), hazard stall, ID-stage
// redirects with targets, halt detect; outputs pc, pc4, valid, flush,
// halted and fetch count.
module pc_fetch_unit #(
    parameter int BITS_SIZE = pc_fetch_unit_pkg::BITS_SIZE,
    parameter logic [BITS_SIZE-1:0] PC_RESET =
        pc_fetch_unit_pkg::PC_RESET,
    parameter int PC_INC = pc_fetch_unit_pkg::PC_INC
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [BITS_SIZE-1:0] i_pc_branch,
    input  logic                 i_jump,
    input  logic [BITS_SIZE-1:0] i_pc_jump,
    input  logic                 i_jump_reg,
    input  logic [BITS_SIZE-1:0] i_pc_jreg,
    input  logic                 i_halt_detected,
    output logic [BITS_SIZE-1:0] o_pc,
    output logic [BITS_SIZE-1:0] o_pc4,
    output logic                 o_valid,
    output logic                 o_flush,
    output logic                 o_halted,
    output logic [BITS_SIZE-1:0] o_fetch_count
);

    import pc_fetch_unit_pkg::*;

    localparam logic [BITS_SIZE-1:0] INC_W = BITS_SIZE'(PC_INC);

    fetch_state_e         state_q;
    fetch_state_e         state_d;
    logic [BITS_SIZE-1:0] pc_q;
    logic [BITS_SIZE-1:0] pc_next;
    logic [BITS_SIZE-1:0] count_q;
    logic                 halted_q;
    logic                 upd_en;
    logic                 load;
    logic                 redirect;
    logic                 halt_go;

    pc_next_mux #(
        .BITS_SIZE (BITS_SIZE)
    ) u_next_mux (
        .i_upd_en       (upd_en),
        .i_stall        (i_stall),
        .i_halt         (i_halt_detected),
        .i_branch_taken (i_branch_taken),
        .i_pc_branch    (i_pc_branch),
        .i_jump_reg     (i_jump_reg),
        .i_pc_jreg      (i_pc_jreg),
        .i_jump         (i_jump),
        .i_pc_jump      (i_pc_jump),
        .i_pc           (pc_q),
        .i_pc4          (o_pc4),
        .o_pc_next      (pc_next),
        .o_load         (load),
        .o_redirect     (redirect)
    );

    // A HALT only takes effect if it is on the correct path and the
    // pipeline is not stalled.
    assign halt_go = upd_en & i_halt_detected & ~redirect & ~i_stall;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = i_step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_go) begin
                    state_d = ST_HALT;
                end else if (i_step_mode) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (halt_go) begin
                    state_d = ST_HALT;
                end else if (!i_step_mode) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        upd_en = 1'b0;
        unique case (state_q)
            ST_RUN:  upd_en = 1'b1;
            ST_STEP: upd_en = i_step;
            default: upd_en = 1'b0;
        endcase
    end

    // PC register, fetch counter and halted flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q     <= PC_RESET;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            if (load) begin
                pc_q    <= pc_next;
                count_q <= count_q + 1'b1;
            end
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign o_pc          = pc_q;
    assign o_pc4         = pc_q + INC_W;
    assign o_flush       = redirect;
    assign o_valid       = upd_en & ~i_stall & ~redirect
                         & ~i_halt_detected;
    assign o_halted      = halted_q;
    assign o_fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Hand-computed expectations; one summary line at the end.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        stall;
    logic        branch_taken;
    logic [31:0] pc_branch;
    logic        jump;
    logic [31:0] pc_jump;
    logic        jump_reg;
    logic [31:0] pc_jreg;
    logic        halt_det;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        flush;
    logic        halted;
    logic [31:0] fcount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_step_mode     (step_mode),
        .i_step          (step),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_pc_branch     (pc_branch),
        .i_jump          (jump),
        .i_pc_jump       (pc_jump),
        .i_jump_reg      (jump_reg),
        .i_pc_jreg       (pc_jreg),
        .i_halt_detected (halt_det),
        .o_pc            (pc),
        .o_pc4           (pc4),
        .o_valid         (valid),
        .o_flush         (flush),
        .o_halted        (halted),
        .o_fetch_count   (fcount)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        step_mode    = 1'b0;
        step         = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        pc_branch    = '0;
        jump         = 1'b0;
        pc_jump      = '0;
        jump_reg     = 1'b0;
        pc_jreg      = '0;
        halt_det     = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_cnt", fcount, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);

        // Free run: 0,4,8,12,16
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_pc0", pc, 32'h0);
        check("run_valid", {31'b0, valid}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("run_pc", pc, 32'(4 * i));
        end
        check("run_cnt", fcount, 32'd4);
        for (int i = 0; i < 4; i++) tick();
        check("run_pc20", pc, 32'h20);

        // Branch beats stall
        branch_taken = 1'b1;
        pc_branch    = 32'h100;
        stall        = 1'b1;
        #1;
        check("br_flush", {31'b0, flush}, 32'h1);
        check("br_valid", {31'b0, valid}, 32'h0);
        tick();
        stall = 1'b0;
        check("br_pc", pc, 32'h100);
        check("br_cnt", fcount, 32'd9);

        // Redirect priority
        pc_branch = 32'h40;
        jump      = 1'b1;
        pc_jump   = 32'h80;
        jump_reg  = 1'b1;
        pc_jreg   = 32'hC0;
        tick();
        check("pri_br", pc, 32'h40);
        branch_taken = 1'b0;
        tick();
        check("pri_jr", pc, 32'hC0);
        jump_reg = 1'b0;
        pc_jump  = 32'h83;
        tick();
        jump = 1'b0;
        check("pri_j_align", pc, 32'h80);
        check("pri_cnt", fcount, 32'd12);

        // Halt on wrong path is squashed
        halt_det     = 1'b1;
        branch_taken = 1'b1;
        pc_branch    = 32'h200;
        tick();
        halt_det     = 1'b0;
        branch_taken = 1'b0;
        #1;
        check("sq_pc", pc, 32'h200);
        check("sq_halted", {31'b0, halted}, 32'h0);
        check("sq_valid", {31'b0, valid}, 32'h1);

        // Real halt at 0x30
        jump    = 1'b1;
        pc_jump = 32'h30;
        tick();
        jump     = 1'b0;
        halt_det = 1'b1;
        #1;
        check("h_valid", {31'b0, valid}, 32'h0);
        tick();
        halt_det = 1'b0;
        check("h_pc", pc, 32'h30);
        check("h_halted", {31'b0, halted}, 32'h1);
        check("h_cnt", fcount, 32'd14);
        start        = 1'b1;
        step         = 1'b1;
        branch_taken = 1'b1;
        pc_branch    = 32'h500;
        #1;
        check("h_flush", {31'b0, flush}, 32'h0);
        tick();
        tick();
        check("h_stay_pc", pc, 32'h30);
        check("h_stay", {31'b0, halted}, 32'h1);
        check("h_stay_cnt", fcount, 32'd14);
        start        = 1'b0;
        step         = 1'b0;
        branch_taken = 1'b0;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        check("hr_pc", pc, 32'h0);
        check("hr_halted", {31'b0, halted}, 32'h0);
        check("hr_cnt", fcount, 32'h0);

        // Single step
        start     = 1'b1;
        step_mode = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("st_idle_pc", pc, 32'h0);
        check("st_valid0", {31'b0, valid}, 32'h0);
        step = 1'b1;
        #1;
        check("st_valid1", {31'b0, valid}, 32'h1);
        tick();
        step = 1'b0;
        check("st_pc", pc, 32'h4);
        tick();
        check("st_hold", pc, 32'h4);
        step  = 1'b1;
        stall = 1'b1;
        tick();
        step  = 1'b0;
        stall = 1'b0;
        tick();
        check("st_stall_pc", pc, 32'h4);
        check("st_cnt", fcount, 32'd1);

        // Back to run, wrap at top of address space
        step_mode = 1'b0;
        tick();
        check("wr_pc", pc, 32'h4);
        jump    = 1'b1;
        pc_jump = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        check("wr_top", pc, 32'hFFFF_FFFC);
        check("wr_pc4", pc4, 32'h0);
        tick();
        check("wr_pc0", pc, 32'h0);
        check("wr_cnt", fcount, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
